// File: rtl/cpu6_memarb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu6_memarb : shares one variable-latency memory between fetch (I) and      |
// |               load/store (D). CPU6_MEMARB_RR_EN selects round-robin ties.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module cpu6_memarb #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_req,
    input  logic [XLEN-1:0] i_addr,
    output logic            i_done,
    output logic [XLEN-1:0] i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_done,
    output logic [XLEN-1:0] d_rdata,
    output logic            m_req,
    output logic            m_we,
    output logic [XLEN-1:0] m_addr,
    output logic [XLEN-1:0] m_wdata,
    input  logic            m_ready,
    input  logic [XLEN-1:0] m_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    state_t          state_q;
    logic            owner_q;
    logic            m_req_q;
    logic            m_we_q;
    logic [XLEN-1:0] m_addr_q;
    logic [XLEN-1:0] m_wdata_q;
    logic            i_done_q;
    logic            d_done_q;
    logic [XLEN-1:0] i_rdata_q;
    logic [XLEN-1:0] d_rdata_q;
    logic            pick_dport;

`ifdef CPU6_MEMARB_RR_EN
    // On a tie the port that was not served last wins.
    assign pick_dport = d_req & (~i_req | (owner_q == OWN_I));
`else
    assign pick_dport = d_req;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            owner_q   <= OWN_I;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    i_done_q <= 1'b0;
                    d_done_q <= 1'b0;
                    if (i_req || d_req) begin
                        state_q <= S_BUSY;
                        m_req_q <= 1'b1;
                        if (pick_dport) begin
                            owner_q   <= OWN_D;
                            m_we_q    <= d_we;
                            m_addr_q  <= d_addr;
                            m_wdata_q <= d_wdata;
                        end else begin
                            owner_q   <= OWN_I;
                            m_we_q    <= 1'b0;
                            m_addr_q  <= i_addr;
                            m_wdata_q <= '0;
                        end
                    end
                end
                S_BUSY: begin
                    if (m_ready) begin
                        state_q <= S_RESP;
                        m_req_q <= 1'b0;
                        if (owner_q == OWN_I) begin
                            i_done_q  <= 1'b1;
                            i_rdata_q <= m_rdata;
                        end else begin
                            d_done_q <= 1'b1;
                            if (!m_we_q) begin
                                d_rdata_q <= m_rdata;
                            end
                        end
                    end
                end
                S_RESP: begin
                    // No re-arbitration here so a still-high req is not granted twice.
                    state_q  <= S_IDLE;
                    i_done_q <= 1'b0;
                    d_done_q <= 1'b0;
                end
                default: begin
                    state_q  <= S_IDLE;
                    m_req_q  <= 1'b0;
                    i_done_q <= 1'b0;
                    d_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign i_done  = i_done_q;
    assign d_done  = d_done_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu6_memarb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cpu6_memarb : directed self-checking bench for cpu6_memarb.             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_cpu6_memarb;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ready;
    logic [31:0] m_rdata;

    int n_total;
    int n_bad;

    cpu6_memarb #(.XLEN(32)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_done  (i_done),
        .i_rdata (i_rdata),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_done  (d_done),
        .d_rdata (d_rdata),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_ready (m_ready),
        .m_rdata (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_d;
        n_total = 0;
        n_bad   = 0;
        reset   = 1'b1;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        m_ready = 1'b0;
        m_rdata = '0;

        // Reset asserted mid-cycle, no edge involved.
        tick();
        tick();
        #3;
        reset = 1'b0;
        #1;
        check("rst_m_req",   {31'd0, m_req},  32'd0);
        check("rst_m_we",    {31'd0, m_we},   32'd0);
        check("rst_m_addr",  m_addr,          32'd0);
        check("rst_m_wdata", m_wdata,         32'd0);
        check("rst_i_done",  {31'd0, i_done}, 32'd0);
        check("rst_d_done",  {31'd0, d_done}, 32'd0);
        check("rst_i_rdata", i_rdata,         32'd0);
        check("rst_d_rdata", d_rdata,         32'd0);
        tick();
        reset = 1'b1;
        tick();
        check("idle_m_req", {31'd0, m_req}, 32'd0);

        // Single fetch, memory ready on the third BUSY cycle.
        i_req  = 1'b1;
        i_addr = 32'h100;
        tick();
        check("f_m_req1", {31'd0, m_req}, 32'd1);
        check("f_m_addr", m_addr,         32'h100);
        check("f_m_we",   {31'd0, m_we},  32'd0);
        tick();
        check("f_m_req2", {31'd0, m_req}, 32'd1);
        tick();
        check("f_m_req3", {31'd0, m_req}, 32'd1);
        m_ready = 1'b1;
        m_rdata = 32'h00500093;
        tick();
        i_req   = 1'b0;
        m_ready = 1'b0;
        check("f_i_done",  {31'd0, i_done}, 32'd1);
        check("f_i_rdata", i_rdata,         32'h00500093);
        check("f_d_done",  {31'd0, d_done}, 32'd0);
        check("f_m_req_r", {31'd0, m_req},  32'd0);
        tick();
        check("f_i_done0", {31'd0, i_done}, 32'd0);
        check("f_i_hold",  i_rdata,         32'h00500093);

        // Store with memory ready immediately; m_ready high in IDLE is ignored.
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h2000;
        d_wdata = 32'hDEADBEEF;
        m_ready = 1'b1;
        m_rdata = 32'h12345678;
        tick();
        check("s_m_req",   {31'd0, m_req}, 32'd1);
        check("s_m_we",    {31'd0, m_we},  32'd1);
        check("s_m_addr",  m_addr,         32'h2000);
        check("s_m_wdata", m_wdata,        32'hDEADBEEF);
        tick();
        d_req = 1'b0;
        d_we  = 1'b0;
        check("s_d_done",  {31'd0, d_done}, 32'd1);
        check("s_i_done",  {31'd0, i_done}, 32'd0);
        check("s_d_rdata", d_rdata,         32'd0);
        tick();
        check("s_d_done0", {31'd0, d_done}, 32'd0);

        // Load updates d_rdata, fetch data untouched.
        d_req   = 1'b1;
        d_addr  = 32'h44;
        m_rdata = 32'hCAFEF00D;
        tick();
        check("l_m_we", {31'd0, m_we}, 32'd0);
        tick();
        d_req = 1'b0;
        check("l_d_done",  {31'd0, d_done}, 32'd1);
        check("l_d_rdata", d_rdata,         32'hCAFEF00D);
        check("l_i_hold",  i_rdata,         32'h00500093);
        tick();

        // Fresh reset so the owner register is I in both builds.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // Collision: D first (done cycle 2), then I (done cycle 5).
        i_req   = 1'b1;
        i_addr  = 32'h104;
        d_req   = 1'b1;
        d_addr  = 32'h3000;
        m_ready = 1'b1;
        m_rdata = 32'hA5A50001;
        tick();
        check("c1_m_addr", m_addr, 32'h3000);
        tick();
        d_req   = 1'b0;
        m_rdata = 32'h0BADC0DE;
        check("c2_d_done", {31'd0, d_done}, 32'd1);
        check("c2_i_done", {31'd0, i_done}, 32'd0);
        check("c2_d_rdata", d_rdata,        32'hA5A50001);
        tick();
        check("c3_m_req",  {31'd0, m_req},  32'd0);
        check("c3_d_done", {31'd0, d_done}, 32'd0);
        tick();
        check("c4_m_req",  {31'd0, m_req}, 32'd1);
        check("c4_m_addr", m_addr,         32'h104);
        tick();
        i_req = 1'b0;
        check("c5_i_done",  {31'd0, i_done}, 32'd1);
        check("c5_i_rdata", i_rdata,         32'h0BADC0DE);
        tick();

        // Both held continuously for four grants.
        i_req = 1'b1;
        d_req = 1'b1;
        for (int g = 0; g < 4; g++) begin
`ifdef CPU6_MEMARB_RR_EN
            exp_d = (g % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            m_rdata = 32'h1000 + g;
            tick();
            check("h_m_addr", m_addr, exp_d ? 32'h3000 : 32'h104);
            tick();
            check("h_d_done", {31'd0, d_done}, {31'd0, exp_d});
            check("h_i_done", {31'd0, i_done}, {31'd0, ~exp_d});
            if (exp_d) check("h_d_rdata", d_rdata, 32'h1000 + g);
            else       check("h_i_rdata", i_rdata, 32'h1000 + g);
            tick();
        end
        i_req = 1'b0;
        d_req = 1'b0;
        tick();
        tick();

        // Reset in the middle of an access abandons it.
        m_ready = 1'b0;
        i_req   = 1'b1;
        i_addr  = 32'h200;
        tick();
        check("r_m_req1", {31'd0, m_req}, 32'd1);
        tick();
        #2;
        reset = 1'b0;
        #1;
        check("r_m_req_async", {31'd0, m_req},  32'd0);
        check("r_i_done",      {31'd0, i_done}, 32'd0);
        m_ready = 1'b1;
        tick();
        check("r_i_done_hold", {31'd0, i_done}, 32'd0);
        reset   = 1'b1;
        m_ready = 1'b0;
        m_rdata = 32'h77;
        tick();
        check("r_regrant_req",  {31'd0, m_req}, 32'd1);
        check("r_regrant_addr", m_addr,         32'h200);
        m_ready = 1'b1;
        tick();
        i_req   = 1'b0;
        m_ready = 1'b0;
        check("r_i_done_end", {31'd0, i_done}, 32'd1);
        check("r_i_rdata",    i_rdata,         32'h77);
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu6_memarb.md
# cpu6_memarb

Two-port memory arbiter placed between the cpu6 core and a single-ported, variable-latency memory. It shares the memory between the instruction-fetch port (I) and the load/store port (D). It grants one requester at a time, sequences the access through a small FSM, and returns a registered done pulse and read data to the granted requester. The core uses the done pulses to drive its fetch stall and memory-stage stall logic.

## Interface
Parameters:
- XLEN, 32, address and data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, asynchronous, active-low.
- i_req  in  1  fetch request; held high until i_done.
- i_addr  in  XLEN  fetch address; stable while i_req is high.
- i_done  out  1  one-cycle pulse: fetch complete, i_rdata valid.
- i_rdata  out  XLEN  fetched instruction; holds its value until the next fetch completes.
- d_req  in  1  data request; held high until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  XLEN  data address.
- d_wdata  in  XLEN  store data.
- d_done  out  1  one-cycle pulse: data access complete.
- d_rdata  out  XLEN  load data; holds its value until the next load completes.
- m_req  out  1  memory request; held high until m_ready.
- m_we  out  1  memory write enable.
- m_addr  out  XLEN  memory address.
- m_wdata  out  XLEN  memory write data.
- m_ready  in  1  memory completes the access this cycle; m_rdata is valid this cycle when m_we=0.
- m_rdata  in  XLEN  memory read data.

## Operation
- FSM states: IDLE, BUSY, RESP. The FSM also keeps an owner register (I or D).
- IDLE, with no request pending: stay in IDLE.
- IDLE, with at least one request pending: the arbiter grants one requester and moves to BUSY.
  - The owner register takes the granted port.
  - m_addr, m_we and m_wdata are registered from the granted port.
  - An I grant forces m_we to 0 and m_wdata to 0.
- Arbitration is fixed priority: D beats I, because the data access belongs to the older instruction. The Configuration section describes the alternative.
- BUSY: m_req is 1 and the m_* outputs are frozen.
  - m_ready=0: stay in BUSY. There is no timeout.
  - m_ready=1: move to RESP. If the owner issued a load or a fetch, the owner's rdata register captures m_rdata at that edge. A store leaves d_rdata unchanged.
- RESP: the owner's done output is 1 for exactly this cycle and m_req is 0. RESP always moves to IDLE next.
  - RESP does not re-arbitrate, so a requester whose req is still high in the done cycle is never granted twice.
- Dropping req while BUSY has no effect. The access completes and the done pulse still fires.
- Requests that arrive while BUSY or RESP stay pending, because requesters hold req high. They are arbitrated in the next IDLE cycle.
- i_done and d_done are never high in the same cycle.
- Reset:
  - State goes to IDLE immediately, asynchronously.
  - m_req, m_we, i_done and d_done go to 0.
  - m_addr, m_wdata, i_rdata and d_rdata go to 0.
  - The owner register goes to I.
- Reset in the middle of an access abandons it. There is no done pulse, and memory sees m_req fall with no handshake.

## Timing
- Request high in IDLE at cycle T: m_req is high from T+1.
- m_ready high at cycle T+k (k≥1): done pulses at T+k+1 and the FSM is in IDLE at T+k+2.
- Best case, with m_ready in the first BUSY cycle, the done pulse comes 2 cycles after the request. Sustained throughput is one access per 3 cycles.
- Back-to-back example: with m_ready=1 in every BUSY cycle and both requesters pending, D is served with done at cycle 2. I is granted at the cycle-3 edge, with m_req high at cycle 4 and i_done at cycle 5.
- m_ready is ignored outside BUSY.
- All outputs are registered. Nothing passes combinationally from any input to any output.

## Configuration
- CPU6_MEMARB_RR_EN, defined: round-robin arbitration.
  - On a tie in IDLE, the port that is not in the owner register (the last-served port) wins.
  - The owner register resets to I, so the first tie goes to D.
  - A single requester always wins regardless of the owner register.
- CPU6_MEMARB_RR_EN, undefined: fixed priority, D always beats I.
- All other behaviour and timing is identical in both builds.

## Test plan
- Reset: assert reset low in the middle of a cycle, with no clock edge. All outputs go to 0 immediately, and after release the FSM is in IDLE.
- Single fetch: i_req=1, i_addr=0x100, m_ready=1 on the 3rd BUSY cycle with m_rdata=0x00500093. Response: m_req high for 3 cycles with m_addr=0x100 and m_we=0, then i_done for 1 cycle with i_rdata=0x00500093. No d_done pulse occurs.
- Store: d_req=1, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, m_ready immediate. Response: m_we=1, m_addr=0x2000, m_wdata=0xDEADBEEF, then d_done for 1 cycle. d_rdata is unchanged.
- Collision, fixed priority (macro undefined): i_req and d_req both raised at the same cycle and held, m_ready immediate. Response: D is served first with d_done at cycle 2, then i_done at cycle 5.
- Collision with CPU6_MEMARB_RR_EN defined: both requests held continuously. Grants alternate D, I, D, I. With the macro undefined, D is served repeatedly for as long as d_req is re-raised after each d_done.
- Reset during an access: reset pulsed while BUSY with m_ready=0. Response: m_req falls asynchronously, no done pulse occurs, and after release a pending i_req is granted normally.
